// File: rtl/usb3_pkt_framer_if.sv
`default_nettype none
// ============================================================================
// Module   : usb3_pkt_framer_if
// Purpose  : Request, payload-RAM and FX3 slave-FIFO signals of the packet framer.
// Revision : 1.0
// ============================================================================
interface usb3_pkt_framer_if #(
    parameter int ADDR_W = 8
);
    logic              pkt_req;
    logic [2:0]        pkt_type;
    logic              pkt_ack;
    logic              pkt_done;
    logic              pkt_err;
    logic              busy;
    logic              src_rd_en;
    logic [ADDR_W-1:0] src_addr;
    logic [31:0]       src_data;
    logic              usb_full_n;
    logic [31:0]       usb_data;
    logic              usb_slwr_n;
    logic              usb_pktend_n;

    modport master (
        input  pkt_req, pkt_type, src_data, usb_full_n,
        output pkt_ack, pkt_done, pkt_err, busy, src_rd_en, src_addr,
               usb_data, usb_slwr_n, usb_pktend_n
    );

    modport slave (
        output pkt_req, pkt_type, src_data, usb_full_n,
        input  pkt_ack, pkt_done, pkt_err, busy, src_rd_en, src_addr,
               usb_data, usb_slwr_n, usb_pktend_n
    );
endinterface
`default_nettype wire

// File: rtl/usb3_pkt_framer.sv
`default_nettype none
// ============================================================================
// Module   : usb3_pkt_framer
// Purpose  : Frames {FF,code,FF} header + payload RAM words into the FX3 write FIFO.
// Revision : 1.0
// ============================================================================
module usb3_pkt_framer #(
    parameter int PAYLOAD_WORDS = 255,
    parameter int ADDR_W        = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    usb3_pkt_framer_if.master   bus
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] PW_CNT   = CNT_W'(PAYLOAD_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PAY  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic             ack_nxt, err_nxt, done_nxt;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;
    logic             in_flight;
    logic [1:0]       occ;
    logic [31:0]      skid0, skid1;
    logic [31:0]      hdr_word;
    logic             pkt_ack_r, pkt_done_r, pkt_err_r;
    logic [31:0]      usb_data_r;
    logic             slwr_n_r, pktend_n_r;

    logic             type_ok;
    logic             active;
    logic             avail;
    logic             do_wr;
    logic             last_wr;
    logic             rd_issue;
    logic             pop, bypass, push;
    logic [31:0]      wr_word;

    function automatic logic [15:0] type_code(input logic [2:0] t);
        case (t)
            3'd2:    type_code = 16'h000A;
            3'd3:    type_code = 16'h00AA;
            3'd4:    type_code = 16'h0AAA;
            3'd5:    type_code = 16'hAAAA;
            default: type_code = 16'h0000;
        endcase
    endfunction

    assign type_ok  = (bus.pkt_type >= 3'd1) && (bus.pkt_type <= 3'd5);
    assign active   = (state == S_HDR) || (state == S_PAY);
    // A word is writable from the header, the skid head, or the RAM read landing this cycle.
    assign avail    = (state == S_HDR) || ((state == S_PAY) && ((occ != 2'd0) || in_flight));
    assign do_wr    = avail && bus.usb_full_n;
    assign last_wr  = do_wr && (state == S_PAY) && (wr_cnt == LAST_CNT);
    assign rd_issue = active && (rd_cnt < PW_CNT) &&
                      (({1'b0, occ} + {2'b00, in_flight}) < 3'd2);
    assign pop      = do_wr && (state == S_PAY) && (occ != 2'd0);
    assign bypass   = do_wr && (state == S_PAY) && (occ == 2'd0);
    assign push     = in_flight && !bypass;
    assign wr_word  = (state == S_HDR) ? hdr_word :
                      (occ != 2'd0)    ? skid0    : bus.src_data;

    always_comb begin
        state_nxt = state;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.pkt_req) begin
                    if (type_ok) begin
                        state_nxt = S_HDR;
                        ack_nxt   = 1'b1;
                    end else begin
                        err_nxt   = 1'b1;
                    end
                end
            end
            S_HDR:  if (do_wr) state_nxt = S_PAY;
            S_PAY: begin
                if (last_wr) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pkt_ack_r  <= 1'b0;
            pkt_done_r <= 1'b0;
            pkt_err_r  <= 1'b0;
        end else begin
            state      <= state_nxt;
            pkt_ack_r  <= ack_nxt;
            pkt_done_r <= done_nxt;
            pkt_err_r  <= err_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            in_flight  <= 1'b0;
            occ        <= 2'd0;
            skid0      <= '0;
            skid1      <= '0;
            hdr_word   <= '0;
            usb_data_r <= '0;
            slwr_n_r   <= 1'b1;
            pktend_n_r <= 1'b1;
        end else begin
            if (state == S_IDLE && state_nxt == S_HDR)
                hdr_word <= {8'hFF, type_code(bus.pkt_type), 8'hFF};

            if (state == S_DONE)
                rd_cnt <= '0;
            else if (rd_issue)
                rd_cnt <= rd_cnt + 1'b1;
            in_flight <= rd_issue;

            if (state == S_DONE)
                wr_cnt <= '0;
            else if (do_wr && state == S_PAY)
                wr_cnt <= wr_cnt + 1'b1;

            // Fetch throttling keeps occupancy + in-flight <= 2, so a push never overflows.
            case ({push, pop})
                2'b11: begin
                    if (occ == 2'd2) begin
                        skid0 <= skid1;
                        skid1 <= bus.src_data;
                    end else begin
                        skid0 <= bus.src_data;
                    end
                end
                2'b10: begin
                    if (occ == 2'd0) skid0 <= bus.src_data;
                    else             skid1 <= bus.src_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    skid0 <= skid1;
                    occ   <= occ - 2'd1;
                end
                default: ;
            endcase

            slwr_n_r   <= ~do_wr;
            pktend_n_r <= ~last_wr;
            if (do_wr) usb_data_r <= wr_word;
        end
    end

    assign bus.pkt_ack      = pkt_ack_r;
    assign bus.pkt_done     = pkt_done_r;
    assign bus.pkt_err      = pkt_err_r;
    assign bus.busy         = (state != S_IDLE);
    assign bus.src_rd_en    = rd_issue;
    assign bus.src_addr     = rd_cnt[ADDR_W-1:0];
    assign bus.usb_data     = usb_data_r;
    assign bus.usb_slwr_n   = slwr_n_r;
    assign bus.usb_pktend_n = pktend_n_r;
endmodule
`default_nettype wire

// File: tb/tb_usb3_pkt_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb3_pkt_framer
// Purpose  : Directed self-checking bench for usb3_pkt_framer.
// Revision : 1.0
// ============================================================================
module tb_usb3_pkt_framer;
    localparam int PW = 255;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usb3_pkt_framer_if #(.ADDR_W(AW)) bus();

    usb3_pkt_framer #(.PAYLOAD_WORDS(PW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] ram [0:255];
    initial for (int i = 0; i < 256; i++) ram[i] = 32'(i);
    always @(posedge clk) if (bus.src_rd_en) bus.src_data <= ram[bus.src_addr];

    logic [31:0] wr_q [$];
    bit          pe_q [$];
    int          cyc_q [$];
    int          cyc = 0;
    int          ack_cnt = 0, done_cnt = 0, err_cnt = 0, viol = 0, pe_bad = 0, ack_cyc = 0;
    logic        full_prev = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (!bus.usb_slwr_n) begin
            wr_q.push_back(bus.usb_data);
            pe_q.push_back(!bus.usb_pktend_n);
            cyc_q.push_back(cyc);
        end
        if (!bus.usb_pktend_n && bus.usb_slwr_n) pe_bad++;
        if (!bus.usb_slwr_n && !full_prev) viol++;
        full_prev = bus.usb_full_n;
        if (bus.pkt_ack) begin ack_cnt++; ack_cyc = cyc; end
        if (bus.pkt_done) done_cnt++;
        if (bus.pkt_err) err_cnt++;
    end

    function automatic logic [31:0] exp_word(input int i, input logic [31:0] hdr);
        return (i == 0) ? hdr : 32'(i - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_q.delete(); pe_q.delete(); cyc_q.delete();
        ack_cnt = 0; done_cnt = 0; err_cnt = 0; viol = 0; pe_bad = 0;
    endtask

    // mode 0: never full, 1: 10-cycle stall after payload word 99, 2: random full_n
    task automatic run_packet(input logic [2:0] typ, input int mode, output bit ok);
        int  stall_left = 0;
        bit  stalled    = 0;
        ok = 0;
        bus.pkt_type   = typ;
        bus.pkt_req    = 1'b1;
        bus.usb_full_n = 1'b1;
        for (int c = 0; c < 4000 && !ok; c++) begin
            tick();
            if (ack_cnt > 0) bus.pkt_req = 1'b0;
            if (done_cnt > 0) ok = 1;
            if (mode == 1) begin
                if (!stalled && wr_q.size() >= 101) begin stalled = 1; stall_left = 10; end
                bus.usb_full_n = (stall_left > 0) ? 1'b0 : 1'b1;
                if (stall_left > 0) stall_left--;
            end else if (mode == 2) begin
                bus.usb_full_n = 1'($urandom_range(0, 1));
            end
        end
        bus.pkt_req    = 1'b0;
        bus.usb_full_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.usb_slwr_n, bus.usb_pktend_n, bus.src_rd_en, bus.busy,
             bus.pkt_ack, bus.pkt_done, bus.pkt_err} !== 7'b1100000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 1100000",
                     {bus.usb_slwr_n, bus.usb_pktend_n, bus.src_rd_en, bus.busy,
                      bus.pkt_ack, bus.pkt_done, bus.pkt_err});
        end
        checks++;
        if (bus.usb_data !== 32'h0) begin
            failures++; $display("FAIL reset_data: got %h expected 00000000", bus.usb_data);
        end
        checks++;
        if (bus.src_addr !== 8'h0) begin
            failures++; $display("FAIL reset_addr: got %h expected 00", bus.src_addr);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        int bad = -1;
        int pbad = -1;
        clear_mon();
        run_packet(3'd1, 0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_timeout: got no pkt_done expected done"); end
        checks++;
        if (wr_q.size() != PW + 1) begin
            failures++; $display("FAIL basic_count: got %0d expected %0d", wr_q.size(), PW + 1);
        end
        for (int i = 0; i < wr_q.size() && i <= PW; i++) begin
            if (bad < 0 && wr_q[i] !== exp_word(i, 32'hFF0000FF)) bad = i;
            if (pbad < 0 && pe_q[i] != (i == PW)) pbad = i;
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL basic_stream: idx %0d got %h expected %h", bad, wr_q[bad],
                     exp_word(bad, 32'hFF0000FF));
        end
        checks++;
        if (pbad >= 0 || pe_bad != 0) begin
            failures++; $display("FAIL basic_pktend: got idx %0d stray %0d expected only idx %0d",
                                 pbad, pe_bad, PW);
        end
        checks++;
        if (cyc_q.size() == 0 || cyc_q[0] != ack_cyc + 1) begin
            failures++; $display("FAIL basic_latency: got hdr cycle %0d expected %0d",
                                 (cyc_q.size() != 0) ? cyc_q[0] : -1, ack_cyc + 1);
        end
        checks++;
        if (cyc_q.size() == PW + 1 && cyc_q[PW] - cyc_q[0] != PW) begin
            failures++; $display("FAIL basic_rate: got span %0d expected %0d", cyc_q[PW] - cyc_q[0], PW);
        end
        checks++;
        if (done_cnt != 1 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL basic_done: got done=%0d busy=%b expected 1/0", done_cnt, bus.busy);
        end
    endtask

    task automatic test_types();
        bit ok;
        logic [2:0] bad_types [3];
        clear_mon();
        run_packet(3'd5, 0, ok);
        checks++;
        if (!ok || wr_q.size() != PW + 1 || wr_q[0] !== 32'hFFAAAAFF) begin
            failures++; $display("FAIL type5_hdr: got %h n=%0d expected FFAAAAFF n=%0d",
                                 (wr_q.size() != 0) ? wr_q[0] : 32'h0, wr_q.size(), PW + 1);
        end
        bad_types[0] = 3'd7; bad_types[1] = 3'd0; bad_types[2] = 3'd6;
        for (int k = 0; k < 3; k++) begin
            clear_mon();
            bus.pkt_type = bad_types[k];
            bus.pkt_req  = 1'b1;
            tick();
            checks++;
            if (bus.pkt_err !== 1'b1 || bus.busy !== 1'b0) begin
                failures++; $display("FAIL err_pulse type %0d: got err=%b busy=%b expected 1/0",
                                     bad_types[k], bus.pkt_err, bus.busy);
            end
            bus.pkt_req = 1'b0;
            repeat (4) tick();
            checks++;
            if (err_cnt != 1 || ack_cnt != 0 || wr_q.size() != 0) begin
                failures++; $display("FAIL err_quiet type %0d: got err=%0d ack=%0d wr=%0d expected 1/0/0",
                                     bad_types[k], err_cnt, ack_cnt, wr_q.size());
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        int bad = -1;
        int gap = 0;
        clear_mon();
        run_packet(3'd1, 1, ok);
        for (int i = 0; i < wr_q.size() && i <= PW; i++)
            if (bad < 0 && wr_q[i] !== exp_word(i, 32'hFF0000FF)) bad = i;
        for (int i = 1; i < cyc_q.size(); i++)
            if (cyc_q[i] - cyc_q[i-1] > gap) gap = cyc_q[i] - cyc_q[i-1];
        checks++;
        if (!ok || wr_q.size() != PW + 1 || bad >= 0) begin
            failures++; $display("FAIL stall_stream: got n=%0d bad_idx=%0d expected n=%0d bad_idx=-1",
                                 wr_q.size(), bad, PW + 1);
        end
        checks++;
        if (viol != 0) begin failures++; $display("FAIL stall_write_when_full: got %0d expected 0", viol); end
        checks++;
        if (gap < 10) begin failures++; $display("FAIL stall_gap: got %0d expected >=10", gap); end
    endtask

    task automatic test_random();
        bit ok;
        int bad = -1;
        clear_mon();
        run_packet(3'd4, 2, ok);
        for (int i = 0; i < wr_q.size() && i <= PW; i++)
            if (bad < 0 && wr_q[i] !== exp_word(i, 32'hFF0AAAFF)) bad = i;
        checks++;
        if (!ok || wr_q.size() != PW + 1 || bad >= 0) begin
            failures++; $display("FAIL random_stream: got n=%0d bad_idx=%0d expected n=%0d bad_idx=-1",
                                 wr_q.size(), bad, PW + 1);
        end
        checks++;
        if (viol != 0 || pe_bad != 0 || (pe_q.size() == PW + 1 && !pe_q[PW])) begin
            failures++; $display("FAIL random_flags: got viol=%0d stray_pktend=%0d expected 0/0", viol, pe_bad);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit reached = 0;
        int pe_seen = 0;
        int bad = -1;
        clear_mon();
        bus.pkt_type = 3'd1;
        bus.pkt_req  = 1'b1;
        for (int c = 0; c < 1000 && !reached; c++) begin
            tick();
            if (ack_cnt > 0) bus.pkt_req = 1'b0;
            if (wr_q.size() >= 41) reached = 1;
        end
        bus.pkt_req = 1'b0;
        checks++;
        if (!reached) begin failures++; $display("FAIL midrst_reach: got %0d writes expected 41", wr_q.size()); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.usb_slwr_n, bus.usb_pktend_n, bus.src_rd_en, bus.busy} !== 4'b1100 ||
            bus.usb_data !== 32'h0 || bus.src_addr !== 8'h0) begin
            failures++; $display("FAIL midrst_outputs: got ctl=%b data=%h addr=%h expected 1100/0/0",
                                 {bus.usb_slwr_n, bus.usb_pktend_n, bus.src_rd_en, bus.busy},
                                 bus.usb_data, bus.src_addr);
        end
        tick();
        rst = 1'b0;
        tick();
        foreach (pe_q[i]) if (pe_q[i]) pe_seen++;
        checks++;
        if (pe_seen != 0 || pe_bad != 0) begin
            failures++; $display("FAIL midrst_pktend: got %0d expected 0", pe_seen + pe_bad);
        end
        clear_mon();
        run_packet(3'd1, 0, ok);
        for (int i = 0; i < wr_q.size() && i <= PW; i++)
            if (bad < 0 && wr_q[i] !== exp_word(i, 32'hFF0000FF)) bad = i;
        checks++;
        if (!ok || wr_q.size() != PW + 1 || bad >= 0) begin
            failures++; $display("FAIL midrst_restart: got n=%0d bad_idx=%0d expected n=%0d bad_idx=-1",
                                 wr_q.size(), bad, PW + 1);
        end
    endtask

    task automatic test_back_to_back();
        bit done = 0;
        int bad  = -1;
        clear_mon();
        bus.pkt_type   = 3'd2;
        bus.pkt_req    = 1'b1;
        bus.usb_full_n = 1'b1;
        for (int c = 0; c < 3000 && !done; c++) begin
            tick();
            if (ack_cnt >= 1) bus.pkt_type = 3'd3;
            if (ack_cnt >= 2) bus.pkt_req = 1'b0;
            if (done_cnt >= 2) done = 1;
        end
        bus.pkt_req = 1'b0;
        repeat (2) tick();
        checks++;
        if (!done || done_cnt != 2 || wr_q.size() != 2 * (PW + 1)) begin
            failures++; $display("FAIL b2b_count: got done=%0d n=%0d expected 2/%0d",
                                 done_cnt, wr_q.size(), 2 * (PW + 1));
        end
        for (int i = 0; i < wr_q.size() && i < 2 * (PW + 1); i++) begin
            if (bad < 0 && i <= PW && wr_q[i] !== exp_word(i, 32'hFF000AFF)) bad = i;
            if (bad < 0 && i > PW && wr_q[i] !== exp_word(i - PW - 1, 32'hFF00AAFF)) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            failures++; $display("FAIL b2b_stream: idx %0d got %h", bad, wr_q[bad]);
        end
        checks++;
        if (wr_q.size() == 2 * (PW + 1) &&
            (cyc_q[PW + 1] - cyc_q[PW] < 2 || !pe_q[PW] || !pe_q[2 * PW + 1])) begin
            failures++; $display("FAIL b2b_gap: got gap %0d pktend %b%b expected >=2 and 11",
                                 cyc_q[PW + 1] - cyc_q[PW], pe_q[PW], pe_q[2 * PW + 1]);
        end
    endtask

    initial begin
        bus.pkt_req    = 1'b0;
        bus.pkt_type   = 3'd1;
        bus.usb_full_n = 1'b1;
        test_reset();
        test_basic();
        test_types();
        test_stall();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
